adc_spi_master: RTL

SPI master that drives the external 10-bit ADC (MCP3002-style, SPI mode 0,0) and delivers one parallel sample per fixed sample period. It is the stage directly upstream of the sample-processing and Pi-output logic in the FPGA top level. It generates the ADC sclk/ncs/dout lines, captures the serial ADC output, and presents each sample with a one-cycle valid strobe.

---
 rtl/adc_spi_master.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_master.sv
// adc_spi_master: SPI mode (0,0) master for an MCP3002-style 10-bit ADC.
// Starts one conversion frame every SAMPLE_PERIOD clocks while enabled,
// sends the start/mode/channel command on dout_o and shifts the result in
// from din_i. Each captured sample is presented on sample_o with a
// one-cycle sample_valid_o strobe.
// Optional build macro: ADC_AVG_EN -- when defined, sample_o is the
// truncated mean of the last four raw captures instead of the raw value.
module adc_spi_master #(
    parameter int CLK_DIV       = 8,
    parameter int FRAME_BITS    = 16,
    parameter int SAMPLE_BITS   = 10,
    parameter int SAMPLE_PERIOD = 1024
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  logic                   channel_i,
    input  logic                   din_i,
    output logic                   sclk_o,
    output logic                   dout_o,
    output logic                   ncs_o,
    output logic [SAMPLE_BITS-1:0] sample_o,
    output logic                   sample_valid_o,
    output logic                   busy_o
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int KW = $clog2(FRAME_BITS);
    localparam int PW = $clog2(SAMPLE_PERIOD);

    localparam logic [CW-1:0] CNT_MAX      = CW'(CLK_DIV - 1);
    localparam logic [KW-1:0] K_LAST       = KW'(FRAME_BITS - 1);
    localparam logic [KW-1:0] K_FIRST_DATA = KW'(FRAME_BITS - SAMPLE_BITS);
    localparam logic [PW-1:0] PCNT_MAX     = PW'(SAMPLE_PERIOD - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Parameter sanity: a frame plus its turnaround must fit in one period.
    if (CLK_DIV < 2) begin : g_bad_div
        $error("adc_spi_master: CLK_DIV must be at least 2");
    end
    if (SAMPLE_BITS > FRAME_BITS - 5) begin : g_bad_bits
        $error("adc_spi_master: SAMPLE_BITS must not exceed FRAME_BITS-5");
    end
    if (SAMPLE_PERIOD <= (2 * FRAME_BITS + 1) * CLK_DIV + 2) begin : g_bad_period
        $error("adc_spi_master: SAMPLE_PERIOD too short for one frame");
    end

    // Command bit driven during sclk period k: start, single-ended, channel,
    // MSB-first, then zeros while the ADC returns its result.
    function automatic logic cmd_bit(input logic [KW-1:0] k, input logic ch);
        case (k)
            KW'(0), KW'(1), KW'(3): cmd_bit = 1'b1;
            KW'(2):                 cmd_bit = ch;
            default:                cmd_bit = 1'b0;
        endcase
    endfunction

    logic [1:0]             state_q, state_d;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   high_q, high_d;
    logic                   ch_q, ch_d;
    logic                   sclk_q, sclk_d;
    logic                   dout_q, dout_d;
    logic                   ncs_q, ncs_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic [SAMPLE_BITS-1:0] sample_q, sample_d;
    logic [SAMPLE_BITS-1:0] result;

`ifdef ADC_AVG_EN
    localparam int SW = SAMPLE_BITS + 2;
    logic [SAMPLE_BITS-1:0] hist1_q, hist1_d;
    logic [SAMPLE_BITS-1:0] hist2_q, hist2_d;
    logic [SAMPLE_BITS-1:0] hist3_q, hist3_d;
    logic [SW-1:0]          avg_sum;

    // Mean of the frame just captured and the three before it.
    always_comb begin
        avg_sum = SW'(shift_q) + SW'(hist1_q) + SW'(hist2_q) + SW'(hist3_q);
        result  = avg_sum[SW-1:2];
    end
`else
    assign result = shift_q;
`endif

    // Next-state logic: period counter plus the IDLE/SETUP/XFER/DONE frame FSM.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned
        // (an unassigned path would infer a latch).
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        high_d   = high_q;
        ch_d     = ch_q;
        sclk_d   = sclk_q;
        dout_d   = dout_q;
        ncs_d    = ncs_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        shift_d  = shift_q;
        sample_d = sample_q;
`ifdef ADC_AVG_EN
        hist1_d  = hist1_q;
        hist2_d  = hist2_q;
        hist3_d  = hist3_q;
`endif

        // Free-running period counter, parked at zero while disabled.
        if (!en_i) begin
            pcnt_d = '0;
        end else if (pcnt_q == PCNT_MAX) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (en_i && pcnt_q == '0) begin
                    state_d = ST_SETUP;
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    ch_d    = channel_i;
                    dout_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                // Chip-select setup time before the first sclk edge.
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_XFER;
                    cnt_d   = '0;
                    k_d     = '0;
                    high_d  = 1'b0;
                    dout_d  = cmd_bit('0, ch_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_XFER: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (!high_q) begin
                        // Rising sclk: ADC data is stable, capture result bits.
                        high_d = 1'b1;
                        sclk_d = 1'b1;
                        if (k_q >= K_FIRST_DATA) begin
                            shift_d = {shift_q[SAMPLE_BITS-2:0], din_i};
                        end
                    end else begin
                        // Falling sclk: move to the next bit and its command.
                        high_d = 1'b0;
                        sclk_d = 1'b0;
                        if (k_q == K_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            k_d    = k_q + KW'(1);
                            dout_d = cmd_bit(k_q + KW'(1), ch_q);
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                ncs_d    = 1'b1;
                busy_d   = 1'b0;
                dout_d   = 1'b0;
                valid_d  = 1'b1;
                sample_d = result;
`ifdef ADC_AVG_EN
                hist1_d  = shift_q;
                hist2_d  = hist1_q;
                hist3_d  = hist2_q;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset takes effect immediately, aborting any frame.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            pcnt_q   <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            high_q   <= 1'b0;
            ch_q     <= 1'b0;
            sclk_q   <= 1'b0;
            dout_q   <= 1'b0;
            ncs_q    <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            shift_q  <= '0;
            sample_q <= '0;
`ifdef ADC_AVG_EN
            // NOTE: the history is reset on purpose -- the first averages
            // after reset are defined to include zeros.
            hist1_q  <= '0;
            hist2_q  <= '0;
            hist3_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            high_q   <= high_d;
            ch_q     <= ch_d;
            sclk_q   <= sclk_d;
            dout_q   <= dout_d;
            ncs_q    <= ncs_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
`ifdef ADC_AVG_EN
            hist1_q  <= hist1_d;
            hist2_q  <= hist2_d;
            hist3_q  <= hist3_d;
`endif
        end
    end

    assign sclk_o         = sclk_q;
    assign dout_o         = dout_q;
    assign ncs_o          = ncs_q;
    assign busy_o         = busy_q;
    assign sample_valid_o = valid_q;
    assign sample_o       = sample_q;

endmodule
